// File: rtl/shift_pipe.sv
// ---------------------------------------------------------------------------
// shift_pipe
//
// Pipelined multi-mode barrel shifter for the execute datapath. One register
// stage per shift-amount bit: stage k conditionally shifts by 2^k, so an
// operation takes SHAMT_WIDTH cycles from accept to out_valid when the
// consumer is not stalling. A sideband tag travels with every operation.
//
// Modes (in_mode):
//   000 SLL   logical left, zero fill
//   001 SRL   logical right, zero fill
//   010 SRA   arithmetic right, sign fill
//   011 ROL   rotate left
//   100 ROR   rotate right
//   101..111  pass-through, data unchanged
//
// Handshake (valid/ready):
//   A transfer happens on a rising edge where valid & ready are both high.
//   The producer side may change in_* freely while in_ready is low; nothing
//   is captured then. The consumer side holds out_* stable while
//   out_valid & ~out_ready. The stall is global: every stage holds together,
//   bubbles included, and in_ready = ~stall is purely combinational.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset, highest priority
//   in_valid   operation presented on in_*
//   in_ready   shifter accepts an operation this cycle
//   in_data    operand (OPERAND_WIDTH)
//   in_shamt   unsigned shift amount (SHAMT_WIDTH), implicitly mod width
//   in_mode    operation select (3 bits)
//   in_tag     opaque sideband tag (TAG_WIDTH)
//   out_valid  result valid on out_*
//   out_ready  consumer takes the result this cycle
//   out_data   shifted result
//   out_tag    tag of the result
//   out_zero   registered "result is all zeros" flag
//
// OPERAND_WIDTH must be a power of two (>= 4) and SHAMT_WIDTH its log2.
// ---------------------------------------------------------------------------
module shift_pipe #(
    parameter int OPERAND_WIDTH = 16,
    parameter int SHAMT_WIDTH   = 4,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [OPERAND_WIDTH-1:0] in_data,
    input  logic [SHAMT_WIDTH-1:0]   in_shamt,
    input  logic [2:0]               in_mode,
    input  logic [TAG_WIDTH-1:0]     in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OPERAND_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]     out_tag,
    output logic                     out_zero
);

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROL = 3'b011;
    localparam logic [2:0] MODE_ROR = 3'b100;

    localparam int NS = SHAMT_WIDTH;

    // -----------------------------------------------------------------------
    // Stage registers
    // -----------------------------------------------------------------------
    logic [NS-1:0]            valid_q, valid_d;
    logic [OPERAND_WIDTH-1:0] data_q  [NS];
    logic [OPERAND_WIDTH-1:0] data_d  [NS];
    logic [2:0]               mode_q  [NS];
    logic [2:0]               mode_d  [NS];
    // Remaining shift-amount bits, right-aligned: each stage consumes bit 0
    // of its source and stores the rest shifted down by one.
    logic [SHAMT_WIDTH-1:0]   shamt_q [NS];
    logic [SHAMT_WIDTH-1:0]   shamt_d [NS];
    logic [TAG_WIDTH-1:0]     tag_q   [NS];
    logic [TAG_WIDTH-1:0]     tag_d   [NS];
    // Zero flag lives alongside the last stage only.
    logic                     zero_q, zero_d;

    // -----------------------------------------------------------------------
    // Stage sources: in_* for S0, previous stage register otherwise
    // -----------------------------------------------------------------------
    logic [NS-1:0]            src_valid;
    logic [OPERAND_WIDTH-1:0] src_data  [NS];
    logic [2:0]               src_mode  [NS];
    logic [SHAMT_WIDTH-1:0]   src_shamt [NS];
    logic [TAG_WIDTH-1:0]     src_tag   [NS];

    logic stall;
    logic accept;

    // One fixed-distance shift step. n is always a power of two no larger
    // than OPERAND_WIDTH/2, so the rotate complement shifts stay in range.
    function automatic logic [OPERAND_WIDTH-1:0] shift_step(
        input logic [OPERAND_WIDTH-1:0] d,
        input logic [2:0]               mode,
        input int unsigned              n
    );
        logic [OPERAND_WIDTH-1:0] ones;
        logic [OPERAND_WIDTH-1:0] fill;
        logic [OPERAND_WIDTH-1:0] r;
        ones = '1;
        // Sign bit sampled from this stage's input, replicated.
        fill = {OPERAND_WIDTH{d[OPERAND_WIDTH-1]}};
        case (mode)
            MODE_SLL: r = d << n;
            MODE_SRL: r = d >> n;
            MODE_SRA: r = (d >> n) | (fill & ~(ones >> n));
            MODE_ROL: r = (d << n) | (d >> (OPERAND_WIDTH - n));
            MODE_ROR: r = (d >> n) | (d << (OPERAND_WIDTH - n));
            default:  r = d;
        endcase
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    always_comb begin
        stall  = valid_q[NS-1] & ~out_ready;
        accept = in_valid & ~stall;
    end

    assign in_ready = ~stall;

    // -----------------------------------------------------------------------
    // Source selection
    // -----------------------------------------------------------------------
    always_comb begin
        src_valid    = '0;
        src_valid[0] = accept;
        src_data[0]  = in_data;
        src_mode[0]  = in_mode;
        src_shamt[0] = in_shamt;
        src_tag[0]   = in_tag;
        for (int k = 1; k < NS; k++) begin
            src_valid[k] = valid_q[k-1];
            src_data[k]  = data_q[k-1];
            src_mode[k]  = mode_q[k-1];
            src_shamt[k] = shamt_q[k-1];
            src_tag[k]   = tag_q[k-1];
        end
    end

    // -----------------------------------------------------------------------
    // Next-state: advance everything, or hold everything on a stall
    // -----------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        shamt_d = shamt_q;
        tag_d   = tag_q;
        zero_d  = zero_q;
        if (!stall) begin
            for (int k = 0; k < NS; k++) begin
                valid_d[k] = src_valid[k];
                data_d[k]  = src_shamt[k][0]
                           ? shift_step(src_data[k], src_mode[k], 32'(1) << k)
                           : src_data[k];
                mode_d[k]  = src_mode[k];
                shamt_d[k] = src_shamt[k] >> 1;
                tag_d[k]   = src_tag[k];
            end
            // Flag is computed from the value being loaded into the last
            // stage, so it is registered together with out_data.
            zero_d = (data_d[NS-1] == '0);
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            zero_q  <= 1'b0;
            for (int k = 0; k < NS; k++) begin
                data_q[k]  <= '0;
                mode_q[k]  <= '0;
                shamt_q[k] <= '0;
                tag_q[k]   <= '0;
            end
        end else begin
            valid_q <= valid_d;
            zero_q  <= zero_d;
            for (int k = 0; k < NS; k++) begin
                data_q[k]  <= data_d[k];
                mode_q[k]  <= mode_d[k];
                shamt_q[k] <= shamt_d[k];
                tag_q[k]   <= tag_d[k];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign out_valid = valid_q[NS-1];
    assign out_data  = data_q[NS-1];
    assign out_tag   = tag_q[NS-1];
    assign out_zero  = zero_q;

    // The last stage keeps mode and (now empty) remaining shamt for
    // uniformity with the other stages; nothing downstream reads them.
    logic unused_last_stage;
    assign unused_last_stage = ^{mode_q[NS-1], shamt_q[NS-1]};

endmodule

// File: tb/tb_shift_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_pipe
//
// Directed and random checks of shift_pipe at width 16. A scoreboard fed by
// accepted inputs (through an independent reference model) checks every
// result the DUT hands over; directed sections add latency, handshake,
// stall-stability and reset checks.
// ---------------------------------------------------------------------------
module tb_shift_pipe;

  localparam int W  = 16;
  localparam int SW = 4;
  localparam int TW = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [2:0]    in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_zero;

  always #5 clk = ~clk;

  shift_pipe #(
    .OPERAND_WIDTH(W),
    .SHAMT_WIDTH  (SW),
    .TAG_WIDTH    (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag),
    .out_zero (out_zero)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s,
                                         input logic [2:0] m);
    logic [2*W-1:0] dd;
    logic signed [W-1:0] sd;
    dd = {d, d};
    sd = d;
    case (m)
      3'b000:  return d << s;
      3'b001:  return d >> s;
      3'b010:  return W'(sd >>> s);
      3'b011:  begin dd = dd << s; return dd[2*W-1:W]; end
      3'b100:  begin dd = dd >> s; return dd[W-1:0]; end
      default: return d;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Scoreboard: {zero, tag, data}
  // -------------------------------------------------------------------------
  logic [W+TW:0] exp_q[$];
  logic [W+TW:0] sb_e;
  logic [W-1:0]  sb_r;
  int            n_delivered = 0;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          sb_e = exp_q.pop_front();
          check("sb_data", 32'(out_data), 32'(sb_e[W-1:0]));
          check("sb_tag",  32'(out_tag),  32'(sb_e[W+TW-1:W]));
          check("sb_zero", 32'(out_zero), 32'(sb_e[W+TW]));
          n_delivered++;
        end
      end
      if (in_valid && in_ready) begin
        sb_r = model(in_data, in_shamt, in_mode);
        exp_q.push_back({sb_r == '0, in_tag, sb_r});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] m, input logic [W-1:0] d,
                        input logic [SW-1:0] s, input logic [TW-1:0] t);
    in_mode  = m;
    in_data  = d;
    in_shamt = s;
    in_tag   = t;
  endtask

  // Single op with empty pipe and out_ready=1; measures accept-to-valid latency.
  task automatic run_single(input string name, input logic [2:0] m, input logic [W-1:0] d,
                            input logic [SW-1:0] s, input logic [TW-1:0] t,
                            input logic [W-1:0] exp_d, input logic exp_z);
    int lat;
    logic seen;
    set_op(m, d, s, t);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < 12) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      else begin
        tick();
        lat++;
      end
    end
    check({name, "_latency"}, 32'(lat), 32'd4);
    check({name, "_data"}, 32'(out_data), 32'(exp_d));
    check({name, "_tag"}, 32'(out_tag), 32'(t));
    check({name, "_zero"}, 32'(out_zero), 32'(exp_z));
    tick();
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  logic [15:0]   vmask;
  int            first_c;
  int            i;
  int            d0;
  logic [W-1:0]  hold_data;
  logic [TW-1:0] hold_tag;
  int            n_acc;
  int            cyc;
  int            n_out;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_op(3'b000, '0, '0, '0);
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_tag",   32'(out_tag),   32'd0);
    check("rst_out_zero",  32'(out_zero),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    tick();

    // Directed single operations (hand-computed results).
    run_single("sll15",  3'b000, 16'h0001, 4'd15, 4'h1, 16'h8000, 1'b0);
    run_single("srl15",  3'b001, 16'h8000, 4'd15, 4'h2, 16'h0001, 1'b0);
    run_single("sra4",   3'b010, 16'h8000, 4'd4,  4'h3, 16'hF800, 1'b0);
    run_single("rol1",   3'b011, 16'h8001, 4'd1,  4'h4, 16'h0003, 1'b0);
    run_single("ror4",   3'b100, 16'h1234, 4'd4,  4'h5, 16'h4123, 1'b0);
    run_single("pass6",  3'b110, 16'hBEEF, 4'd7,  4'h6, 16'hBEEF, 1'b0);
    run_single("sll8",   3'b000, 16'h00FF, 4'd8,  4'h7, 16'hFF00, 1'b0);
    run_single("srl_z",  3'b001, 16'h000F, 4'd4,  4'h8, 16'h0000, 1'b1);
    run_single("sra_pos",3'b010, 16'h7FF0, 4'd3,  4'h9, 16'h0FFE, 1'b0);
    run_single("sra15",  3'b010, 16'h8001, 4'd15, 4'hA, 16'hFFFF, 1'b0);
    run_single("ror15",  3'b100, 16'h0001, 4'd15, 4'hB, 16'h0002, 1'b0);
    run_single("rol0",   3'b011, 16'h1234, 4'd0,  4'hC, 16'h1234, 1'b0);
    run_single("pass7z", 3'b111, 16'h0000, 4'd3,  4'hD, 16'h0000, 1'b1);
    run_single("pass5",  3'b101, 16'h8421, 4'd9,  4'hE, 16'h8421, 1'b0);

    // Throughput: 8 back-to-back ops, valid expected in cycles 4..11.
    vmask   = '0;
    first_c = -1;
    for (int c = 0; c < 16; c++) begin
      in_valid = (c < 8);
      set_op(3'b000, 16'(c * 16'h0111), 4'd1, 4'(c));
      @(negedge clk);
      if (c < 8) check("tp_in_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        vmask[c] = 1'b1;
        if (first_c < 0) first_c = c;
      end
      tick();
    end
    in_valid = 1'b0;
    check("tp_first_valid", 32'(first_c), 32'd4);
    check("tp_valid_mask", 32'(vmask), 32'h0FF0);

    // Backpressure: out_ready low in cycles 4..6.
    i  = 0;
    d0 = n_delivered;
    for (int c = 0; c < 16; c++) begin
      out_ready = !(c >= 4 && c < 7);
      in_valid  = (i < 6);
      set_op(3'b100, 16'(16'hA0C3 + i), 4'(i + 1), 4'(8 + i));
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'(!(c >= 4 && c < 7)));
      if (c == 4) begin
        hold_data = out_data;
        hold_tag  = out_tag;
        check("bp_stall_valid", 32'(out_valid), 32'd1);
      end
      if (c == 5 || c == 6) begin
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_data", 32'(out_data), 32'(hold_data));
        check("bp_hold_tag",  32'(out_tag),  32'(hold_tag));
      end
      if (in_valid && in_ready) i++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_delivered", 32'(n_delivered - d0), 32'd6);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-flight: ops in cycles 0..2, rst in cycle 2.
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      set_op(3'b011, 16'h1111, 4'(c), 4'(c + 3));
      rst = (c == 2);
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    n_out = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid) n_out++;
      tick();
    end
    check("mid_rst_no_output", 32'(n_out), 32'd0);

    // Random regression against the model with random backpressure.
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      set_op(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      @(negedge clk);
      if (in_valid && in_ready) n_acc++;
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("rand_accepted", 32'(n_acc), 32'd10000);
    repeat (12) tick();
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    check("rand_idle_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
